// File: rtl/multdiv_issue_ctrl_if.sv
// Handshake bundle between the execute stage, the shared mult/div units,
// writeback, and the issue controller. The controller uses the slave modport.
interface multdiv_issue_ctrl_if;
    logic        issue_valid;
    logic        issue_op;
    logic [31:0] issue_a;
    logic [31:0] issue_b;
    logic [4:0]  issue_rd;
    logic        issue_ready;
    logic        flush;
    logic        stall;
    logic [31:0] md_operandA;
    logic [31:0] md_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] mult_result;
    logic        mult_exception;
    logic        mult_rdy;
    logic [31:0] div_result;
    logic        div_exception;
    logic        div_rdy;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_exception;
    logic        wb_ack;

    modport slave (
        input  issue_valid, issue_op, issue_a, issue_b, issue_rd, flush,
        input  mult_result, mult_exception, mult_rdy,
        input  div_result, div_exception, div_rdy, wb_ack,
        output issue_ready, stall, md_operandA, md_operandB, ctrl_MULT, ctrl_DIV,
        output wb_valid, wb_rd, wb_data, wb_exception
    );

    modport master (
        output issue_valid, issue_op, issue_a, issue_b, issue_rd, flush,
        output mult_result, mult_exception, mult_rdy,
        output div_result, div_exception, div_rdy, wb_ack,
        input  issue_ready, stall, md_operandA, md_operandB, ctrl_MULT, ctrl_DIV,
        input  wb_valid, wb_rd, wb_data, wb_exception
    );
endinterface

// File: rtl/multdiv_issue_ctrl.sv
// Issue/sequence controller for the shared multiplier/divider datapath.
// Define MULTDIV_TIMEOUT_EN to add the BUSY watchdog and the timeout_err_o port.
module multdiv_issue_ctrl #(
    parameter int unsigned MULT_MIN_CYCLES = 16,
    parameter int unsigned DIV_MIN_CYCLES  = 32,
    parameter int unsigned TIMEOUT_CYCLES  = 64
) (
    input  logic clock_i,
    input  logic reset_n_i,
`ifdef MULTDIV_TIMEOUT_EN
    output logic timeout_err_o,
`endif
    multdiv_issue_ctrl_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_START, S_BUSY, S_DONE} state_e;

    localparam logic [7:0] MULT_MIN = 8'(MULT_MIN_CYCLES);
    localparam logic [7:0] DIV_MIN  = 8'(DIV_MIN_CYCLES);
    localparam logic [4:0] RSTATUS  = 5'd30;

    // The elapsed-cycle counter is 8 bits and saturates, so larger limits could never match.
    if (MULT_MIN_CYCLES > 255 || DIV_MIN_CYCLES > 255 || TIMEOUT_CYCLES > 255) begin : g_cfg_chk
        $error("multdiv_issue_ctrl: cycle limits must fit the 8-bit counter");
    end

    state_e      state_q;
    logic        op_q;
    logic [31:0] a_q, b_q;
    logic [4:0]  rd_q;
    logic [7:0]  cnt_q, cnt_d;
    logic        ctrl_mult_q, ctrl_div_q;
    logic        wb_valid_q, wb_exc_q;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;

    logic [7:0]  min_cyc;
    logic        sel_rdy, sel_exc, rdy_qual, tmo_hit, finish, exc_d;
    logic [31:0] sel_res;

    assign min_cyc  = op_q ? DIV_MIN : MULT_MIN;
    assign sel_rdy  = op_q ? bus.div_rdy       : bus.mult_rdy;
    assign sel_exc  = op_q ? bus.div_exception : bus.mult_exception;
    assign sel_res  = op_q ? bus.div_result    : bus.mult_result;
    // A ready left over from a previous operation is masked until the unit could have finished.
    assign rdy_qual = sel_rdy && (cnt_q >= min_cyc);

`ifdef MULTDIV_TIMEOUT_EN
    localparam logic [7:0] TMO_CNT = 8'(TIMEOUT_CYCLES);
    logic tmo_err_q;
    assign tmo_hit       = !rdy_qual && (cnt_q == TMO_CNT);
    assign timeout_err_o = tmo_err_q;
`else
    assign tmo_hit = 1'b0;
`endif

    assign finish    = rdy_qual | tmo_hit;
    assign exc_d     = tmo_hit | sel_exc;
    assign wb_rd_d   = exc_d ? RSTATUS : rd_q;
    assign wb_data_d = exc_d ? (op_q ? 32'd5 : 32'd4) : sel_res;
    assign cnt_d     = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

    assign bus.issue_ready  = (state_q == S_IDLE);
    assign bus.stall        = (state_q != S_IDLE) | ((state_q == S_IDLE) & bus.issue_valid);
    assign bus.md_operandA  = a_q;
    assign bus.md_operandB  = b_q;
    assign bus.ctrl_MULT    = ctrl_mult_q;
    assign bus.ctrl_DIV     = ctrl_div_q;
    assign bus.wb_valid     = wb_valid_q;
    assign bus.wb_rd        = wb_rd_q;
    assign bus.wb_data      = wb_data_q;
    assign bus.wb_exception = wb_exc_q;

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= S_IDLE;
            op_q        <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            rd_q        <= '0;
            cnt_q       <= '0;
            ctrl_mult_q <= 1'b0;
            ctrl_div_q  <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_exc_q    <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
`ifdef MULTDIV_TIMEOUT_EN
            tmo_err_q   <= 1'b0;
`endif
        end else begin
            ctrl_mult_q <= 1'b0;
            ctrl_div_q  <= 1'b0;
`ifdef MULTDIV_TIMEOUT_EN
            tmo_err_q   <= 1'b0;
`endif
            if (bus.flush) begin
                state_q    <= S_IDLE;
                wb_valid_q <= 1'b0;
            end else begin
                unique case (state_q)
                    S_IDLE: if (bus.issue_valid) begin
                        op_q        <= bus.issue_op;
                        a_q         <= bus.issue_a;
                        b_q         <= bus.issue_b;
                        rd_q        <= bus.issue_rd;
                        cnt_q       <= '0;
                        ctrl_mult_q <= !bus.issue_op;
                        ctrl_div_q  <= bus.issue_op;
                        state_q     <= S_START;
                    end
                    // Counter tracks cycles elapsed since the start strobe.
                    S_START: begin
                        cnt_q   <= 8'd1;
                        state_q <= S_BUSY;
                    end
                    S_BUSY: if (finish) begin
                        wb_valid_q <= 1'b1;
                        wb_exc_q   <= exc_d;
                        wb_rd_q    <= wb_rd_d;
                        wb_data_q  <= wb_data_d;
                        state_q    <= S_DONE;
`ifdef MULTDIV_TIMEOUT_EN
                        tmo_err_q  <= tmo_hit;
`endif
                    end else begin
                        cnt_q <= cnt_d;
                    end
                    S_DONE: if (bus.wb_ack) begin
                        wb_valid_q <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// Directed bench for multdiv_issue_ctrl: mult/div sequencing, exceptions, stale ready, flush, reset.
module tb_multdiv_issue_ctrl;
    logic clock_i   = 1'b0;
    logic reset_n_i = 1'b0;
`ifdef MULTDIV_TIMEOUT_EN
    logic timeout_err_o;
`endif

    multdiv_issue_ctrl_if bus();

    multdiv_issue_ctrl dut (
        .clock_i       (clock_i),
        .reset_n_i     (reset_n_i),
`ifdef MULTDIV_TIMEOUT_EN
        .timeout_err_o (timeout_err_o),
`endif
        .bus           (bus)
    );

    always #5 clock_i = ~clock_i;

    int checks = 0;
    int errors = 0;

    // observations gathered by run_op / ack_op
    int          wb_cyc, n_mult, n_div, n_tmo;
    bit          stall0, opnd_ok, busy_ok, held_ok;
    logic [4:0]  o_rd;
    logic [31:0] o_data;
    logic        o_exc, post_stall, post_wbv, post_rdy;
    logic [105:0] outs;

    task automatic init_inputs();
        bus.issue_valid = 0; bus.issue_op = 0; bus.issue_a = 0; bus.issue_b = 0; bus.issue_rd = 0;
        bus.flush = 0; bus.wb_ack = 0;
        bus.mult_result = 0; bus.mult_exception = 0; bus.mult_rdy = 0;
        bus.div_result = 0; bus.div_exception = 0; bus.div_rdy = 0;
    endtask

    // Issues one op (issue cycle = 0) and follows it until wb_valid or max_cyc.
    task automatic run_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] res, input logic exc,
                          input int rdy_at, input int max_cyc);
        wb_cyc = -1; n_mult = 0; n_div = 0; n_tmo = 0; opnd_ok = 1; busy_ok = 1;
        @(posedge clock_i); #1;
        bus.issue_valid = 1; bus.issue_op = op; bus.issue_a = a; bus.issue_b = b; bus.issue_rd = rd;
        bus.mult_result = res; bus.div_result = res;
        bus.mult_exception = exc & !op; bus.div_exception = exc & op;
        bus.mult_rdy = bus.mult_rdy | (!op && rdy_at <= 0);
        bus.div_rdy  = op && (rdy_at <= 0);
        #1 stall0 = bus.stall;
        @(posedge clock_i); #1;
        bus.issue_valid = 0; bus.issue_a = ~a; bus.issue_b = ~b; bus.issue_rd = ~rd;
        for (int c = 1; c <= max_cyc; c++) begin
            bus.mult_rdy = !op && (c >= rdy_at);
            bus.div_rdy  = op && (c >= rdy_at);
            @(negedge clock_i);
            if (bus.ctrl_MULT === 1'b1) n_mult++;
            if (bus.ctrl_DIV === 1'b1) n_div++;
            if (bus.md_operandA !== a || bus.md_operandB !== b) opnd_ok = 0;
            if (bus.stall !== 1'b1 || bus.issue_ready !== 1'b0) busy_ok = 0;
`ifdef MULTDIV_TIMEOUT_EN
            if (timeout_err_o === 1'b1) n_tmo++;
`endif
            if (bus.wb_valid === 1'b1) begin
                wb_cyc = c; o_rd = bus.wb_rd; o_data = bus.wb_data; o_exc = bus.wb_exception;
                break;
            end
            @(posedge clock_i); #1;
        end
    endtask

    // Holds the writeback one extra cycle, then acks it.
    task automatic ack_op();
        @(negedge clock_i);
        held_ok = (bus.wb_valid === 1'b1) && (bus.stall === 1'b1) && (bus.wb_rd === o_rd)
                  && (bus.wb_data === o_data) && (bus.wb_exception === o_exc);
        bus.wb_ack = 1;
        @(posedge clock_i); #1;
        bus.wb_ack = 0;
        @(negedge clock_i);
        post_stall = bus.stall; post_wbv = bus.wb_valid; post_rdy = bus.issue_ready;
        bus.mult_rdy = 0; bus.div_rdy = 0;
    endtask

    task automatic test_reset();
        init_inputs();
        #3;
        outs = {bus.stall, bus.ctrl_MULT, bus.ctrl_DIV, bus.wb_valid, bus.wb_exception, bus.wb_rd,
                bus.wb_data, bus.md_operandA, bus.md_operandB};
        checks++; if (outs !== '0) begin errors++; $display("FAIL reset_outs: got %h want 0", outs); end
        checks++; if (bus.issue_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.issue_ready); end
        @(negedge clock_i); reset_n_i = 1;
        @(negedge clock_i);
        checks++; if ({bus.issue_ready, bus.stall} !== 2'b10) begin errors++; $display("FAIL idle_after_reset: got %b want 10", {bus.issue_ready, bus.stall}); end
    endtask

    task automatic test_mult_basic();
        run_op(1'b0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 1'b0, 17, 40);
        checks++; if (stall0 !== 1'b1) begin errors++; $display("FAIL mult_stall_comb: got %b want 1", stall0); end
        checks++; if ({n_mult, n_div} !== {32'd1, 32'd0}) begin errors++; $display("FAIL mult_strobes: got mult=%0d div=%0d want 1/0", n_mult, n_div); end
        checks++; if (wb_cyc !== 18) begin errors++; $display("FAIL mult_latency: got %0d want 18", wb_cyc); end
        checks++; if ({o_exc, o_rd, o_data} !== {1'b0, 5'd5, 32'hFFFF_FFEB}) begin errors++; $display("FAIL mult_wb: got exc=%b rd=%0d data=%h want 0/5/ffffffeb", o_exc, o_rd, o_data); end
        checks++; if (busy_ok !== 1'b1) begin errors++; $display("FAIL mult_stall_busy: got %b want 1", busy_ok); end
        ack_op();
        checks++; if (held_ok !== 1'b1) begin errors++; $display("FAIL mult_wb_held: got %b want 1", held_ok); end
        checks++; if ({post_stall, post_wbv, post_rdy} !== 3'b001) begin errors++; $display("FAIL mult_after_ack: got %b want 001", {post_stall, post_wbv, post_rdy}); end
    endtask

    task automatic test_div_basic();
        run_op(1'b1, 32'd100, 32'd7, 5'd9, 32'd14, 1'b0, 33, 60);
        checks++; if ({n_mult, n_div} !== {32'd0, 32'd1}) begin errors++; $display("FAIL div_strobes: got mult=%0d div=%0d want 0/1", n_mult, n_div); end
        checks++; if (wb_cyc !== 34) begin errors++; $display("FAIL div_latency: got %0d want 34", wb_cyc); end
        checks++; if ({o_exc, o_rd, o_data} !== {1'b0, 5'd9, 32'd14}) begin errors++; $display("FAIL div_wb: got exc=%b rd=%0d data=%0d want 0/9/14", o_exc, o_rd, o_data); end
        checks++; if (opnd_ok !== 1'b1) begin errors++; $display("FAIL div_operands_stable: got %b want 1", opnd_ok); end
        ack_op();
        checks++; if ({post_stall, post_wbv, post_rdy} !== 3'b001) begin errors++; $display("FAIL div_after_ack: got %b want 001", {post_stall, post_wbv, post_rdy}); end
    endtask

    task automatic test_exception();
        run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000, 1'b1, 17, 40);
        checks++; if ({o_exc, o_rd, o_data} !== {1'b1, 5'd30, 32'd4}) begin errors++; $display("FAIL mult_exc_wb: got exc=%b rd=%0d data=%0d want 1/30/4", o_exc, o_rd, o_data); end
        ack_op();
        run_op(1'b1, 32'd55, 32'd0, 5'd8, 32'd0, 1'b1, 33, 60);
        checks++; if ({o_exc, o_rd, o_data} !== {1'b1, 5'd30, 32'd5}) begin errors++; $display("FAIL div_exc_wb: got exc=%b rd=%0d data=%0d want 1/30/5", o_exc, o_rd, o_data); end
        ack_op();
    endtask

    task automatic test_stale_rdy();
        bus.mult_rdy = 1; bus.mult_result = 32'hDEAD_BEEF;
        repeat (3) @(posedge clock_i);
        run_op(1'b0, 32'd6, 32'd7, 5'd3, 32'd42, 1'b0, 0, 40);
        checks++; if (wb_cyc !== 18) begin errors++; $display("FAIL stale_rdy_latency: got %0d want 18", wb_cyc); end
        checks++; if ({o_rd, o_data} !== {5'd3, 32'd42}) begin errors++; $display("FAIL stale_rdy_wb: got rd=%0d data=%0d want 3/42", o_rd, o_data); end
        ack_op();
    endtask

    task automatic test_flush_busy();
        int bad_cnt;
        @(posedge clock_i); #1;
        bus.issue_valid = 1; bus.issue_op = 0; bus.issue_a = 32'd2; bus.issue_b = 32'd3; bus.issue_rd = 5'd4;
        @(posedge clock_i); #1;
        bus.issue_valid = 0;
        repeat (5) @(posedge clock_i);
        #1;  // BUSY with count 5
        bus.flush = 1; bus.issue_valid = 1; bus.issue_rd = 5'd7; bus.mult_rdy = 1;
        @(posedge clock_i); #1;
        bus.flush = 0; bus.issue_valid = 0;
        @(negedge clock_i);
        checks++; if ({bus.issue_ready, bus.stall, bus.wb_valid, bus.ctrl_MULT, bus.ctrl_DIV} !== 5'b10000) begin
            errors++; $display("FAIL flush_busy_idle: got %b want 10000", {bus.issue_ready, bus.stall, bus.wb_valid, bus.ctrl_MULT, bus.ctrl_DIV}); end
        bad_cnt = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clock_i);
            if (bus.wb_valid !== 1'b0 || bus.ctrl_MULT !== 1'b0 || bus.issue_ready !== 1'b1) bad_cnt++;
        end
        checks++; if (bad_cnt !== 0) begin errors++; $display("FAIL flush_busy_quiet: got %0d bad cycles want 0", bad_cnt); end
        bus.mult_rdy = 0;
    endtask

    task automatic test_flush_idle_done();
        @(posedge clock_i); #1;
        bus.issue_valid = 1; bus.issue_op = 1; bus.flush = 1;
        @(posedge clock_i); #1;
        bus.issue_valid = 0; bus.flush = 0;
        @(negedge clock_i);
        checks++; if ({bus.issue_ready, bus.ctrl_DIV} !== 2'b10) begin errors++; $display("FAIL flush_idle: got %b want 10", {bus.issue_ready, bus.ctrl_DIV}); end
        run_op(1'b0, 32'd5, 32'd5, 5'd1, 32'd25, 1'b0, 17, 40);
        bus.flush = 1; bus.wb_ack = 1;
        @(posedge clock_i); #1;
        bus.flush = 0; bus.wb_ack = 0; bus.mult_rdy = 0;
        @(negedge clock_i);
        checks++; if ({bus.wb_valid, bus.issue_ready} !== 2'b01) begin errors++; $display("FAIL flush_done: got %b want 01", {bus.wb_valid, bus.issue_ready}); end
    endtask

    task automatic test_reset_mid_busy();
        @(posedge clock_i); #1;
        bus.issue_valid = 1; bus.issue_op = 0; bus.issue_a = 32'd9; bus.issue_b = 32'd9; bus.issue_rd = 5'd4;
        @(posedge clock_i); #1;
        bus.issue_valid = 0;
        repeat (5) @(posedge clock_i);
        #2 reset_n_i = 0;
        #1;
        outs = {bus.stall, bus.ctrl_MULT, bus.ctrl_DIV, bus.wb_valid, bus.wb_exception, bus.wb_rd,
                bus.wb_data, bus.md_operandA, bus.md_operandB};
        checks++; if (outs !== '0) begin errors++; $display("FAIL reset_busy_outs: got %h want 0", outs); end
        checks++; if (bus.issue_ready !== 1'b1) begin errors++; $display("FAIL reset_busy_ready: got %b want 1", bus.issue_ready); end
        @(negedge clock_i); reset_n_i = 1;
    endtask

`ifdef MULTDIV_TIMEOUT_EN
    task automatic test_timeout();
        run_op(1'b0, 32'd1, 32'd1, 5'd6, 32'd1, 1'b0, 1000, 100);
        checks++; if (wb_cyc !== 66) begin errors++; $display("FAIL timeout_latency: got %0d want 66", wb_cyc); end
        checks++; if ({o_exc, o_rd, o_data} !== {1'b1, 5'd30, 32'd4}) begin errors++; $display("FAIL timeout_wb: got exc=%b rd=%0d data=%0d want 1/30/4", o_exc, o_rd, o_data); end
        checks++; if (n_tmo !== 1) begin errors++; $display("FAIL timeout_pulse: got %0d want 1", n_tmo); end
        ack_op();
    endtask
`else
    task automatic test_long_wait();
        run_op(1'b0, 32'd3, 32'd4, 5'd2, 32'd12, 1'b0, 100, 120);
        checks++; if (wb_cyc !== 101) begin errors++; $display("FAIL long_wait_latency: got %0d want 101", wb_cyc); end
        checks++; if ({o_exc, o_rd, o_data} !== {1'b0, 5'd2, 32'd12}) begin errors++; $display("FAIL long_wait_wb: got exc=%b rd=%0d data=%0d want 0/2/12", o_exc, o_rd, o_data); end
        ack_op();
    endtask
`endif

    initial begin
        test_reset();
        test_mult_basic();
        test_div_basic();
        test_exception();
        test_stale_rdy();
        test_flush_busy();
        test_flush_idle_done();
        test_reset_mid_busy();
`ifdef MULTDIV_TIMEOUT_EN
        test_timeout();
`else
        test_long_wait();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end
endmodule
